turfio_cin_align: RTL and testbench
===================================

Name: turfio_cin_align

Overview:
- Automatic IDELAY calibration sequencer for one TURFIO CIN input lane, running in the rxclk domain.
- On start, it drops VTC and sweeps the IDELAY tap value.
- At each tap it dwells and checks the 4-bit ISERDES output against a training pattern, then tracks the widest error-free tap window.
- It then loads the window centre, reads the tap back and re-enables VTC. Downstream CIN logic waits for done_o before bit alignment.

Parameters:
- PATTERN, 4'b1000, training nibble; any of its 4 rotations counts as valid.
- TAP_STEP, 8, tap increment per sweep point (1..64).
- MAX_TAP, 511, last tap value allowed in the sweep.
- DWELL, 256, rxclk cycles checked per tap.
- SETTLE, 16, cycles waited after each LOAD before checking.
- VTC_WAIT, 16, cycles waited after en_vtc_o change.
- MIN_WIDTH, 4, minimum good sweep points for a pass.

Ports:
- rxclk_i  in  1  lane clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start calibration; pulse or level, sampled in IDLE/DONE only
- data_i  in  4  ISERDES nibble from CIN lane
- delay_cntvalue_i  in  9  registered delay readback from lane
- en_vtc_o  out  1  IDELAY/ODELAY VTC enable
- delay_load_o  out  1  one-cycle load strobe
- delay_rd_o  out  1  one-cycle readback strobe
- delay_sel_o  out  2  delay select; always 2'b00 (IDELAY)
- delay_cntvalue_o  out  9  tap value to load
- busy_o  out  1  calibration in progress
- done_o  out  1  level; calibration finished
- fail_o  out  1  level; no window >= MIN_WIDTH found
- eye_start_o  out  9  first tap of best window
- eye_len_o  out  10  best window length in sweep points
- tap_rb_o  out  9  tap read back after final load

Behaviour:
- Reset values: en_vtc_o=1; all other outputs 0. Reset mid-operation aborts immediately to IDLE with these values.
- States: IDLE, VTC_OFF, LOAD, SETTLE, DWELL, EVAL, STEP, CENTER, CSETTLE, READ, RWAIT, VTC_ON, DONE.
- IDLE/DONE:
  - start_i=1 -> VTC_OFF; clears done_o, fail_o and the window registers; sets tap=0 and busy_o=1.
  - start_i while busy is ignored.
- VTC_OFF: en_vtc_o=0; wait VTC_WAIT cycles -> LOAD.
- LOAD: delay_cntvalue_o=tap and delay_load_o=1 for exactly one cycle -> SETTLE.
- SETTLE: wait SETTLE cycles -> DWELL.
- DWELL, over DWELL cycles:
  - The first nibble is captured as the reference.
  - An error flag is set if any nibble is not a rotation of PATTERN, or differs from the reference.
  - Then -> EVAL.
- EVAL (one cycle):
  - Good tap: if cur_len==0 then cur_start=tap; cur_len++.
  - Bad tap: if cur_len>best_len then best=cur; cur_len=0.
  - Comparison is strict >, so on a tie the earlier window wins.
- STEP:
  - next = tap + TAP_STEP, computed at 10 bits.
  - If next <= MAX_TAP: tap=next -> LOAD.
  - Otherwise, perform the final compare of the current window against best -> CENTER.
- CENTER:
  - If best_len >= MIN_WIDTH: final tap = best_start + ((best_len-1)*TAP_STEP)>>1, which is truncating.
  - Otherwise: final tap = 0 and fail is latched.
  - Issue a one-cycle load -> CSETTLE.
- CSETTLE: wait SETTLE cycles -> READ.
- READ: delay_rd_o=1 for one cycle -> RWAIT.
- RWAIT: wait 2 cycles, then capture delay_cntvalue_i into tap_rb_o -> VTC_ON.
- VTC_ON: en_vtc_o=1; wait VTC_WAIT cycles -> DONE. On entering DONE: busy_o=0, done_o=1, and fail_o=1 if fail was latched.
- eye_start_o and eye_len_o update on entry to CENTER and hold until the next start.
- All loads occur with en_vtc_o=0. The strobes never overlap.
- Total latency = 2*VTC_WAIT + npoints*(1+SETTLE+DWELL+2) + SETTLE + 6 cycles (±1, fixed per parameter set), where npoints = floor(MAX_TAP/TAP_STEP)+1.

Decomposition:
- Package turfio_cin_align_pkg: state enum type, tap width (9), length width (10), and a rotation-match function rot_match(nibble, pattern).
- Sub-module turfio_cin_window_track: cur/best start/length registers with good/bad/flush inputs, for isolated unit testing.
- The counters and FSM stay in the top module.

Test Plan:
- Lane model valid (PATTERN rotated by 1, stable) only for taps 96..255, TAP_STEP=8, MAX_TAP=511 -> eye_start_o=96, eye_len_o=20, final load 96+76=172, tap_rb_o=172, done_o=1, fail_o=0.
- Two good windows, 16..63 (6 points) and 200..247 (6 points) -> tie keeps earlier: eye_start_o=16, final tap 36.
- Good region 480..511 touching the sweep end -> final compare at STEP captures it: eye_start_o=480, eye_len_o=4, tap 492, pass.
- Only taps 0..16 good (3 points < MIN_WIDTH) -> fail_o=1, done_o=1, final tap 0, tap_rb_o=0, en_vtc_o=1.
- Single-cycle glitch (non-rotation nibble) inside the dwell at tap 128 in an otherwise good region -> tap 128 counted bad and the window is split.
- rst_i asserted during DWELL -> next cycle en_vtc_o=1, busy_o=0 and strobes 0; start_i during busy has no effect; per-tap load spacing checked for the SETTLE+DWELL+3 cycle period.

Source files
------------

// File: rtl/turfio_cin_align_pkg.sv
// Shared types and helpers for the CIN lane IDELAY calibration sequencer.
package turfio_cin_align_pkg;

  localparam int TAP_W = 9;
  localparam int LEN_W = 10;
  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_VTC_OFF,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_STEP,
    S_CENTER,
    S_CSETTLE,
    S_READ,
    S_RWAIT,
    S_VTC_ON,
    S_DONE
  } cal_state_e;

  // True when nibble equals any of the four rotations of pattern.
  function automatic logic rot_match(input logic [3:0] nibble, input logic [3:0] pattern);
    logic [3:0] rot;
    logic       hit;
    rot = pattern;
    hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (nibble == rot) hit = 1'b1;
      rot = {rot[2:0], rot[3]};
    end
    return hit;
  endfunction

endpackage

// File: rtl/turfio_cin_window_track.sv
// Tracks the current run of good sweep points and the widest run seen so far.
module turfio_cin_window_track
  import turfio_cin_align_pkg::*;
(
  input  logic             rxclk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             good,
  input  logic             bad,
  input  logic             flush,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] fin_start,
  output logic [LEN_W-1:0] fin_len
);

  logic [TAP_W-1:0] cur_start, best_start;
  logic [LEN_W-1:0] cur_len, best_len;

  // Extend the current run on a good tap; close it (strictly wider wins) on bad/flush.
  always_ff @(posedge rxclk_i) begin
    if (rst_i || clr) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (good) begin
      if (cur_len == '0) cur_start <= tap;
      cur_len <= cur_len + LEN_W'(1);
    end else if (bad || flush) begin
      if (cur_len > best_len) begin
        best_start <= cur_start;
        best_len   <= cur_len;
      end
      cur_len <= '0;
    end
  end

  // Best window including a still-open current run, for the end-of-sweep decision.
  always_comb begin
    fin_start = best_start;
    fin_len   = best_len;
    if (cur_len > best_len) begin
      fin_start = cur_start;
      fin_len   = cur_len;
    end
  end

endmodule

// File: rtl/turfio_cin_align.sv
// IDELAY tap sweep / eye-centre calibration sequencer for one TURFIO CIN lane.
module turfio_cin_align
  import turfio_cin_align_pkg::*;
#(
  parameter logic [3:0] PATTERN   = 4'b1000,
  parameter int         TAP_STEP  = 8,
  parameter int         MAX_TAP   = 511,
  parameter int         DWELL     = 256,
  parameter int         SETTLE    = 16,
  parameter int         VTC_WAIT  = 16,
  parameter int         MIN_WIDTH = 4
) (
  input  logic             rxclk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       data_i,
  input  logic [TAP_W-1:0] delay_cntvalue_i,
  output logic             en_vtc_o,
  output logic             delay_load_o,
  output logic             delay_rd_o,
  output logic [1:0]       delay_sel_o,
  output logic [TAP_W-1:0] delay_cntvalue_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [TAP_W-1:0] eye_start_o,
  output logic [LEN_W-1:0] eye_len_o,
  output logic [TAP_W-1:0] tap_rb_o
);

  localparam logic [CNT_W-1:0] VTC_LAST    = CNT_W'(VTC_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);
  localparam logic [LEN_W-1:0] STEP_L      = LEN_W'(TAP_STEP);
  localparam logic [LEN_W-1:0] MAX_TAP_L   = LEN_W'(MAX_TAP);
  localparam logic [LEN_W-1:0] MIN_W_L     = LEN_W'(MIN_WIDTH);

  cal_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [TAP_W-1:0] tap_q, eye_start_q, tap_rb_q, fin_start, final_tap;
  logic [LEN_W-1:0] eye_len_q, fin_len, next_tap;
  logic [16:0]      span;
  logic [3:0]       ref_q;
  logic             err_q, fail_q, accept, sweep_end;

  assign accept    = (state_q == S_IDLE || state_q == S_DONE) && start_i;
  assign next_tap  = {1'b0, tap_q} + STEP_L;
  assign sweep_end = (state_q == S_STEP) && (next_tap > MAX_TAP_L);
  assign span      = 17'(fin_len - LEN_W'(1)) * 17'(TAP_STEP);
  assign final_tap = fin_start + TAP_W'(span >> 1);

  turfio_cin_window_track u_track (
    .rxclk_i   (rxclk_i),
    .rst_i     (rst_i),
    .clr       (accept),
    .good      ((state_q == S_EVAL) && !err_q),
    .bad       ((state_q == S_EVAL) && err_q),
    .flush     (sweep_end),
    .tap       (tap_q),
    .fin_start (fin_start),
    .fin_len   (fin_len)
  );

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d      = state_q;
    en_vtc_o     = 1'b0;
    delay_load_o = 1'b0;
    delay_rd_o   = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE:    begin en_vtc_o = 1'b1; busy_o = 1'b0; if (start_i) state_d = S_VTC_OFF; end
      S_DONE:    begin en_vtc_o = 1'b1; busy_o = 1'b0; done_o = 1'b1;
                       if (start_i) state_d = S_VTC_OFF; end
      S_VTC_OFF: if (cnt_q == VTC_LAST) state_d = S_LOAD;
      S_LOAD:    begin delay_load_o = 1'b1; state_d = S_SETTLE; end
      S_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = S_DWELL;
      S_DWELL:   if (cnt_q == DWELL_LAST) state_d = S_EVAL;
      S_EVAL:    state_d = S_STEP;
      S_STEP:    state_d = sweep_end ? S_CENTER : S_LOAD;
      S_CENTER:  begin delay_load_o = 1'b1; state_d = S_CSETTLE; end
      S_CSETTLE: if (cnt_q == SETTLE_LAST) state_d = S_READ;
      S_READ:    begin delay_rd_o = 1'b1; state_d = S_RWAIT; end
      S_RWAIT:   if (cnt_q == CNT_W'(1)) state_d = S_VTC_ON;
      S_VTC_ON:  begin en_vtc_o = 1'b1; if (cnt_q == VTC_LAST) state_d = S_DONE; end
      default:   state_d = S_IDLE;
    endcase
  end

  // State register, dwell counter and calibration result registers.
  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      fail_q      <= 1'b0;
      eye_start_q <= '0;
      eye_len_q   <= '0;
      tap_rb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      if (accept) begin
        tap_q       <= '0;
        fail_q      <= 1'b0;
        eye_start_q <= '0;
        eye_len_q   <= '0;
      end else if (state_q == S_STEP) begin
        if (!sweep_end) begin
          tap_q <= next_tap[TAP_W-1:0];
        end else begin
          eye_start_q <= fin_start;
          eye_len_q   <= fin_len;
          if (fin_len >= MIN_W_L) begin
            tap_q <= final_tap;
          end else begin
            tap_q  <= '0;
            fail_q <= 1'b1;
          end
        end
      end else if (state_q == S_RWAIT && cnt_q == CNT_W'(1)) begin
        tap_rb_q <= delay_cntvalue_i;
      end
    end
  end

  // Dwell checker: first nibble is the reference, any non-rotation or change flags the tap.
  always_ff @(posedge rxclk_i) begin
    if (state_q == S_DWELL) begin
      if (cnt_q == '0) begin
        ref_q <= data_i;
        err_q <= !rot_match(data_i, PATTERN);
      end else begin
        err_q <= err_q | !rot_match(data_i, PATTERN) | (data_i != ref_q);
      end
    end
  end

  assign delay_sel_o      = 2'b00;
  assign delay_cntvalue_o = tap_q;
  assign fail_o           = done_o && fail_q;
  assign eye_start_o      = eye_start_q;
  assign eye_len_o        = eye_len_q;
  assign tap_rb_o         = tap_rb_q;

endmodule

// File: tb/tb_turfio_cin_align.sv
// Directed bench for turfio_cin_align with a tap-dependent lane model.
module tb_turfio_cin_align;

  localparam int SETTLE   = 4;
  localparam int DWELL    = 16;
  localparam int VTC_WAIT = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] data_i;
  logic [8:0] delay_cntvalue_i;
  logic       en_vtc_o, delay_load_o, delay_rd_o, busy_o, done_o, fail_o;
  logic [1:0] delay_sel_o;
  logic [8:0] delay_cntvalue_o, eye_start_o, tap_rb_o;
  logic [9:0] eye_len_o;

  int tests = 0;
  int fails = 0;

  // Lane model configuration
  int lo1, hi1, lo2, hi2, glitch_tap;
  logic [8:0] lane_tap = '0;
  int since_load = 0;
  int cyc = 0;
  int load_cnt = 0, last_load_cyc = 0, first_gap = 0;
  int vtc_viol = 0, overlap = 0;

  always #5 clk = ~clk;

  turfio_cin_align #(
    .DWELL    (DWELL),
    .SETTLE   (SETTLE),
    .VTC_WAIT (VTC_WAIT)
  ) dut (
    .rxclk_i          (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .data_i           (data_i),
    .delay_cntvalue_i (delay_cntvalue_i),
    .en_vtc_o         (en_vtc_o),
    .delay_load_o     (delay_load_o),
    .delay_rd_o       (delay_rd_o),
    .delay_sel_o      (delay_sel_o),
    .delay_cntvalue_o (delay_cntvalue_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .fail_o           (fail_o),
    .eye_start_o      (eye_start_o),
    .eye_len_o        (eye_len_o),
    .tap_rb_o         (tap_rb_o)
  );

  function automatic logic [3:0] lane_nibble(input logic [8:0] t, input int since);
    int ti;
    ti = int'(t);
    if (ti == glitch_tap && since == 10) return 4'b1111;
    if ((ti >= lo1 && ti <= hi1) || (ti >= lo2 && ti <= hi2)) return 4'b0100;
    return 4'b0000;
  endfunction

  assign data_i           = lane_nibble(lane_tap, since_load);
  assign delay_cntvalue_i = lane_tap;

  // Lane delay line model plus strobe monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (delay_load_o) begin
      lane_tap      <= delay_cntvalue_o;
      since_load    <= 0;
      load_cnt      <= load_cnt + 1;
      last_load_cyc <= cyc;
      if (load_cnt == 1) first_gap <= cyc - last_load_cyc;
      if (en_vtc_o) vtc_viol <= vtc_viol + 1;
      if (delay_rd_o) overlap <= overlap + 1;
    end else begin
      since_load <= since_load + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int a, input int b, input int c, input int d, input int g);
    lo1 = a; hi1 = b; lo2 = c; hi2 = d; glitch_tap = g;
  endtask

  // Pulse start, optionally re-pulse start mid-sweep, wait (bounded) for done.
  task automatic run_cal(input bit mid_start, output bit timed_out);
    load_cnt  = 0;
    timed_out = 1'b1;
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start_i = (mid_start && k == 500);
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int es, input int el, input int ft, input int fl);
    check({tag, "_done"}, int'(done_o), 1);
    check({tag, "_fail"}, int'(fail_o), fl);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_vtc"}, int'(en_vtc_o), 1);
    check({tag, "_eye_start"}, int'(eye_start_o), es);
    check({tag, "_eye_len"}, int'(eye_len_o), el);
    check({tag, "_final_load"}, int'(lane_tap), ft);
    check({tag, "_tap_rb"}, int'(tap_rb_o), ft);
    check({tag, "_loads"}, load_cnt, 65);
  endtask

  initial begin
    bit to;
    set_lane(-1, -1, -1, -1, -1);
    repeat (3) @(negedge clk);
    check("rst_vtc", int'(en_vtc_o), 1);
    check("rst_load", int'(delay_load_o), 0);
    check("rst_rd", int'(delay_rd_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_fail", int'(fail_o), 0);
    check("rst_cntval", int'(delay_cntvalue_o), 0);
    check("rst_sel", int'(delay_sel_o), 0);
    rst_i = 1'b0;

    // Single eye 96..255, with a start pulse while busy that must be ignored
    set_lane(96, 255, -1, -1, -1);
    run_cal(1'b1, to);
    check("t1_timeout", int'(to), 0);
    check_result("t1", 96, 20, 172, 0);
    check("t1_load_gap", first_gap, SETTLE + DWELL + 3);

    // Two equal windows: earlier one wins
    set_lane(16, 63, 200, 247, -1);
    run_cal(1'b0, to);
    check("t2_timeout", int'(to), 0);
    check_result("t2", 16, 6, 36, 0);

    // Window touching the sweep end
    set_lane(480, 511, -1, -1, -1);
    run_cal(1'b0, to);
    check("t3_timeout", int'(to), 0);
    check_result("t3", 480, 4, 492, 0);

    // Too narrow: fail, final tap 0
    set_lane(0, 16, -1, -1, -1);
    run_cal(1'b0, to);
    check("t4_timeout", int'(to), 0);
    check_result("t4", 0, 3, 0, 1);

    // Glitch at tap 128 splits 96..255 into 96..120 and 136..248
    set_lane(96, 255, -1, -1, 128);
    run_cal(1'b0, to);
    check("t5_timeout", int'(to), 0);
    check_result("t5", 136, 15, 192, 0);

    check("load_with_vtc", vtc_viol, 0);
    check("strobe_overlap", overlap, 0);

    // Reset in the middle of a dwell aborts to idle values
    set_lane(96, 255, -1, -1, -1);
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (delay_load_o) begin
        to = 1'b0;
        break;
      end
    end
    check("t6_first_load", int'(to), 0);
    repeat (SETTLE + 5) @(negedge clk);
    check("t6_busy_before", int'(busy_o), 1);
    check("t6_vtc_before", int'(en_vtc_o), 0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("t6_vtc", int'(en_vtc_o), 1);
    check("t6_busy", int'(busy_o), 0);
    check("t6_load", int'(delay_load_o), 0);
    check("t6_rd", int'(delay_rd_o), 0);
    check("t6_done", int'(done_o), 0);
    check("t6_eye_len", int'(eye_len_o), 0);
    @(negedge clk) rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
